// File: rtl/pll_bringup_sequencer.sv
// pll_bringup_sequencer
//   Power-up sequencer for the CDCE62002 SPI programmer. After reset it waits
//   POWERUP_WAIT cycles, requests a programming pass, waits for the programmer
//   to finish, then qualifies the synchronised PLL lock before releasing the
//   DSP from reset. Lock timeout, missing programmer acknowledge or lock loss
//   re-arm the programmer and retry. Once MAX_RETRIES retries have been used,
//   the next failure parks the sequencer in FAULT until reset.
// Ports
//   clk          in   system clock, shared with the programmer
//   reset        in   asynchronous active-low reset
//   prog_active  in   programmer busy flag
//   prog_send    out  programming request (programmer send_data)
//   prog_reset   out  active-high re-arm pulse to the programmer
//   pll_lock     in   raw PLL lock pin, asynchronous
//   dsp_reset_n  out  DSP reset, low holds the DSP in reset
//   pll_ok       out  high while LOCKED
//   pll_fail     out  high while FAULT, sticky until reset
//   retry_count  out  retries used so far, saturating at 15
//   state        out  encoded FSM state (debug only)
module pll_bringup_sequencer #(
  parameter int CNT_W        = 24,
  parameter int POWERUP_WAIT = 1000000,
  parameter int ACK_TIMEOUT  = 16,
  parameter int LOCK_TIMEOUT = 2000000,
  parameter int LOCK_STABLE  = 65536,
  parameter int PROG_RST_LEN = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_active,
  output logic       prog_send,
  output logic       prog_reset,
  input  logic       pll_lock,
  output logic       dsp_reset_n,
  output logic       pll_ok,
  output logic       pll_fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_PWR  = 3'd0,
    START     = 3'd1,
    PROG      = 3'd2,
    LOCK_WAIT = 3'd3,
    LOCKED    = 3'd4,
    REARM     = 3'd5,
    FAULT     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] PWR_LAST    = CNT_W'(POWERUP_WAIT - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCKTO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST   = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PROG_RST_LEN - 1);
  localparam logic [3:0]       MAX_R       = 4'(MAX_RETRIES);

  state_t           cur_state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] stab_cnt;
  logic             lock_p0, lock_p1;
  logic             lock_s;
  logic             retry_req;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign lock_s = lock_p1;
  assign state  = cur_state;

  always_comb begin
    next_state = cur_state;
    retry_req  = 1'b0;
    unique case (cur_state)
      WAIT_PWR:  if (cnt == PWR_LAST) next_state = START;
      START: begin
        if (prog_active)          next_state = PROG;
        else if (cnt == ACK_LAST) retry_req  = 1'b1;
      end
      PROG:      if (!prog_active) next_state = LOCK_WAIT;
      LOCK_WAIT: begin
        // Stable lock takes priority over a simultaneous timeout.
        if (lock_s && stab_cnt == STAB_LAST) next_state = LOCKED;
        else if (cnt == LOCKTO_LAST)         retry_req  = 1'b1;
      end
      LOCKED:    if (!lock_s) retry_req = 1'b1;
      REARM:     if (cnt == RST_LAST) next_state = START;
      FAULT:     next_state = FAULT;
      default:   next_state = WAIT_PWR;
    endcase
    if (retry_req)
      next_state = (retry_count < MAX_R) ? REARM : FAULT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_p0     <= 1'b0;
      lock_p1     <= 1'b0;
      cur_state   <= WAIT_PWR;
      cnt         <= '0;
      stab_cnt    <= '0;
      retry_count <= 4'd0;
      prog_send   <= 1'b0;
      prog_reset  <= 1'b0;
      dsp_reset_n <= 1'b0;
      pll_ok      <= 1'b0;
      pll_fail    <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser for the asynchronous lock pin
      lock_p0 <= pll_lock;
      lock_p1 <= lock_p0;

      // Control stage: state, shared counter, retry bookkeeping
      cur_state <= next_state;
      cnt       <= (next_state != cur_state) ? '0 : cnt + 1'b1;
      stab_cnt  <= (cur_state == LOCK_WAIT && next_state == LOCK_WAIT && lock_s)
                   ? stab_cnt + 1'b1 : '0;
      if (retry_req && next_state == REARM)
        retry_count <= sat_inc(retry_count);

      // Outputs are decoded from next_state so they are valid on the first
      // cycle of each state and change on the same edge as the transition.
      prog_send   <= (next_state == START);
      prog_reset  <= (next_state == REARM);
      dsp_reset_n <= (next_state == LOCKED);
      pll_ok      <= (next_state == LOCKED);
      pll_fail    <= (next_state == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_bringup_sequencer.sv
// tb_pll_bringup_sequencer
//   Directed bench for pll_bringup_sequencer with small timing parameters and
//   a behavioural programmer that raises prog_active one cycle after a request
//   and holds it for 20 cycles.
module tb_pll_bringup_sequencer;

  localparam int S_WAIT = 0, S_START = 1, S_PROG = 2, S_LOCKW = 3,
                 S_LOCKED = 4, S_REARM = 5, S_FAULT = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       prog_active;
  logic       prog_send;
  logic       prog_reset;
  logic       pll_lock;
  logic       dsp_reset_n;
  logic       pll_ok;
  logic       pll_fail;
  logic [3:0] retry_count;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;
  int overlap = 0;
  int bfm_cnt = 0;
  bit bfm_en = 1'b1;

  pll_bringup_sequencer #(
    .CNT_W(24), .POWERUP_WAIT(10), .ACK_TIMEOUT(4), .LOCK_TIMEOUT(50),
    .LOCK_STABLE(8), .PROG_RST_LEN(2), .MAX_RETRIES(2)
  ) dut (
    .clk(clk), .reset(reset), .prog_active(prog_active), .prog_send(prog_send),
    .prog_reset(prog_reset), .pll_lock(pll_lock), .dsp_reset_n(dsp_reset_n),
    .pll_ok(pll_ok), .pll_fail(pll_fail), .retry_count(retry_count), .state(state)
  );

  always #5 clk = ~clk;

  // Programmer model, sharing the board reset with the sequencer
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      prog_active = 1'b0;
      bfm_cnt     = 0;
    end else if (bfm_en) begin
      if (bfm_cnt > 0) begin
        bfm_cnt = bfm_cnt - 1;
        if (bfm_cnt == 0) prog_active = 1'b0;
      end else if (prog_send && !prog_active) begin
        prog_active = 1'b1;
        bfm_cnt     = 20;
      end
    end
  end

  always @(negedge clk) if (prog_send && prog_reset) overlap++;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int st, input int max, output int n);
    n = 0;
    while (int'(state) != st && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  int n, m;

  initial begin
    reset    = 1'b0;
    pll_lock = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_state", int'(state), S_WAIT);
    chk("rst_send", int'(prog_send), 0);
    chk("rst_prst", int'(prog_reset), 0);
    chk("rst_dsp", int'(dsp_reset_n), 0);
    chk("rst_ok", int'(pll_ok), 0);
    chk("rst_fail", int'(pll_fail), 0);
    chk("rst_retry", int'(retry_count), 0);

    // 1: happy path
    reset = 1'b1;
    wait_state(S_START, 100, n);
    chk("t1_start_cyc", n, 10);
    chk("t1_send", int'(prog_send), 1);
    wait_state(S_PROG, 100, n);
    chk("t1_prog_cyc", n, 1);
    chk("t1_send_drop", int'(prog_send), 0);
    wait_state(S_LOCKW, 100, n);
    chk("t1_prog_len", n, 20);
    pll_lock = 1'b1;
    chk("t1_dsp_lw", int'(dsp_reset_n), 0);
    wait_state(S_LOCKED, 100, n);
    chk("t1_lock_cyc", n, 10);
    chk("t1_ok", int'(pll_ok), 1);
    chk("t1_dsp", int'(dsp_reset_n), 1);
    chk("t1_retry", int'(retry_count), 0);

    // 5: one-cycle lock loss in LOCKED
    pll_lock = 1'b0;
    tick();
    chk("t5_ok_hold", int'(pll_ok), 1);
    pll_lock = 1'b1;
    wait_state(S_REARM, 100, m);
    chk("t5_drop_cyc", 1 + m, 3);
    chk("t5_ok", int'(pll_ok), 0);
    chk("t5_dsp", int'(dsp_reset_n), 0);
    chk("t5_retry", int'(retry_count), 1);
    chk("t5_prst", int'(prog_reset), 1);
    wait_state(S_START, 100, n);
    chk("t5_rearm_len", n, 2);
    chk("t5_prst_drop", int'(prog_reset), 0);
    wait_state(S_PROG, 100, n);
    chk("t5_prog_cyc", n, 1);

    // 6: asynchronous reset during PROG
    repeat (5) tick();
    chk("t6_in_prog", int'(state), S_PROG);
    #2 reset = 1'b0;
    #1;
    chk("t6_state", int'(state), S_WAIT);
    chk("t6_retry", int'(retry_count), 0);
    chk("t6_send", int'(prog_send), 0);
    chk("t6_prst", int'(prog_reset), 0);
    chk("t6_dsp", int'(dsp_reset_n), 0);
    tick();
    reset = 1'b1;
    chk("t6_rel_state", int'(state), S_WAIT);
    wait_state(S_START, 100, n);
    chk("t6_restart_cyc", n, 10);

    // 2: lock never asserts
    pll_lock = 1'b0;
    do_reset();
    wait_state(S_LOCKW, 200, n);
    wait_state(S_REARM, 200, n);
    chk("t2_to1", n, 50);
    chk("t2_retry1", int'(retry_count), 1);
    wait_state(S_START, 100, n);
    chk("t2_prst1_len", n, 2);
    wait_state(S_LOCKW, 200, n);
    wait_state(S_REARM, 200, n);
    chk("t2_to2", n, 50);
    chk("t2_retry2", int'(retry_count), 2);
    wait_state(S_START, 100, n);
    chk("t2_prst2_len", n, 2);
    wait_state(S_LOCKW, 200, n);
    wait_state(S_FAULT, 200, n);
    chk("t2_to3", n, 50);
    chk("t2_fail", int'(pll_fail), 1);
    chk("t2_dsp", int'(dsp_reset_n), 0);
    chk("t2_retry3", int'(retry_count), 2);
    repeat (5) tick();
    chk("t2_sticky_state", int'(state), S_FAULT);
    chk("t2_sticky_fail", int'(pll_fail), 1);
    chk("t2_send", int'(prog_send), 0);
    chk("t2_prst", int'(prog_reset), 0);

    // 3: programmer never acknowledges
    bfm_en = 1'b0;
    do_reset();
    wait_state(S_START, 100, n);
    chk("t3_start_cyc", n, 10);
    wait_state(S_REARM, 100, n);
    chk("t3_send_len", n, 4);
    chk("t3_send", int'(prog_send), 0);
    chk("t3_prst", int'(prog_reset), 1);
    chk("t3_retry", int'(retry_count), 1);

    // 4: single lock glitch at stable count 6
    bfm_en   = 1'b1;
    pll_lock = 1'b1;
    do_reset();
    wait_state(S_LOCKW, 200, n);
    repeat (4) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_state(S_LOCKED, 100, n);
    chk("t4_relock_cyc", n, 10);
    chk("t4_ok", int'(pll_ok), 1);

    chk("excl_send_prst", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
